toe_cam_victim_sel: RTL and testbench

Insert-path victim selector for the TOE CAM. It sits directly downstream of the mod-3 random stage and consumes its 2-bit way index (0..2) every cycle. On each insert request it reads the occupancy and lock bits of the addressed 3-way set, then returns the way to write. Free ways are preferred; otherwise the random index picks the eviction victim, with rotation past locked ways.

---
 rtl/toe_cam_victim_sel.sv | 89 ++++++++
 tb/tb_toe_cam_victim_sel.sv | 136 +++++++++++++
 2 files changed

// File: rtl/toe_cam_victim_sel.sv
// toe_cam_victim_sel: insert-path victim selector for a 3-way TOE CAM set.
// A free way is preferred; otherwise Mod picks the victim, rotating past locked ways.
module toe_cam_victim_sel #(
  parameter int A = 8,
  parameter int TMO = 15
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [1:0]   Mod,
  input  logic         ReqValid,
  output logic         ReqReady,
  input  logic [A-1:0] ReqSet,
  output logic         MemRdEn,
  output logic [A-1:0] MemRdAddr,
  input  logic         MemRdVld,
  input  logic [2:0]   MemRdOcc,
  input  logic [2:0]   MemRdLock,
  output logic         RspValid,
  input  logic         RspReady,
  output logic [1:0]   RspWay,
  output logic         RspEvict,
  output logic         RspFail,
  output logic [15:0]  EvictCnt
);
  localparam int CW = $clog2(TMO + 1);
  typedef enum logic [2:0] {IDLE, RD, WAIT, DEC, RSP} state_t;
  state_t state, nxt;
  logic [2:0] occ, lock, free;
  logic [CW-1:0] tmo_cnt;
  logic [1:0] r, r1, r2, d_way;
  logic d_evict, d_fail, tmo_hit;
  always_comb begin
    free = ~occ & ~lock;
    r = (Mod == 2'd3) ? 2'd0 : Mod;
    r1 = (r == 2'd2) ? 2'd0 : r + 2'd1;
    r2 = (r == 2'd0) ? 2'd2 : r - 2'd1;
    d_way = free[0] ? 2'd0 : free[1] ? 2'd1 : free[2] ? 2'd2 :
            !lock[r] ? r : !lock[r1] ? r1 : !lock[r2] ? r2 : 2'd3;
    d_fail = &lock;
    d_evict = ~|free & ~&lock;
    // tmo_cnt counts WAIT cycles already spent, so TMO-1 marks the last allowed cycle
    tmo_hit = state == WAIT && !MemRdVld && tmo_cnt == CW'(TMO - 1);
    nxt = state;
    case (state)
      IDLE: if (ReqValid) nxt = RD;
      RD: nxt = WAIT;
      WAIT: nxt = MemRdVld ? DEC : tmo_hit ? RSP : WAIT;
      DEC: nxt = RSP;
      RSP: if (RspReady) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state <= IDLE;
      ReqReady <= 1'b1;
      MemRdEn <= 1'b0;
      MemRdAddr <= '0;
      RspValid <= 1'b0;
      RspWay <= 2'd0;
      RspEvict <= 1'b0;
      RspFail <= 1'b0;
      EvictCnt <= 16'd0;
      tmo_cnt <= '0;
      occ <= 3'd0;
      lock <= 3'd0;
    end else begin
      state <= nxt;
      ReqReady <= nxt == IDLE;
      MemRdEn <= nxt == RD;
      RspValid <= nxt == RSP;
      tmo_cnt <= (state == WAIT) ? tmo_cnt + CW'(1) : '0;
      if (state == IDLE && ReqValid) MemRdAddr <= ReqSet;
      if (state == WAIT && MemRdVld) begin
        occ <= MemRdOcc;
        lock <= MemRdLock;
      end
      if (state == DEC) begin
        RspWay <= d_way;
        RspEvict <= d_evict;
        RspFail <= d_fail;
      end else if (tmo_hit) begin
        RspWay <= 2'd3;
        RspEvict <= 1'b0;
        RspFail <= 1'b1;
      end
      if (state == RSP && RspReady && RspEvict && ~&EvictCnt) EvictCnt <= EvictCnt + 16'd1;
    end
endmodule

// File: tb/tb_toe_cam_victim_sel.sv
// tb_toe_cam_victim_sel: directed checks of the victim selector with an inline memory responder.
module tb_toe_cam_victim_sel;
  logic Clk = 1'b0, Rst = 1'b0;
  logic [1:0] Mod = 2'd0;
  logic ReqValid = 1'b0, ReqReady;
  logic [7:0] ReqSet = 8'd0;
  logic MemRdEn;
  logic [7:0] MemRdAddr;
  logic MemRdVld = 1'b0;
  logic [2:0] MemRdOcc = 3'd0, MemRdLock = 3'd0;
  logic RspValid, RspReady = 1'b0;
  logic [1:0] RspWay;
  logic RspEvict, RspFail;
  logic [15:0] EvictCnt;
  int checks = 0, errors = 0;
  toe_cam_victim_sel #(.A(8), .TMO(15)) dut (
    .Clk(Clk), .Rst(Rst), .Mod(Mod), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqSet(ReqSet),
    .MemRdEn(MemRdEn), .MemRdAddr(MemRdAddr), .MemRdVld(MemRdVld), .MemRdOcc(MemRdOcc),
    .MemRdLock(MemRdLock), .RspValid(RspValid), .RspReady(RspReady), .RspWay(RspWay),
    .RspEvict(RspEvict), .RspFail(RspFail), .EvictCnt(EvictCnt));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_req(input logic [7:0] set, input int lat, input logic [2:0] occ, input logic [2:0] lock,
                        input logic [1:0] md, input logic [1:0] ew, input logic ee, input logic ef,
                        input logic [15:0] ecnt, input int hold);
    int n;
    @(negedge Clk);
    chk("req_ready_idle", ReqReady, 1'b1);
    ReqValid = 1'b1; ReqSet = set; Mod = md ^ 2'b01;
    @(negedge Clk);
    ReqValid = 1'b0;
    chk("rd_en", MemRdEn, 1'b1);
    chk("rd_addr", MemRdAddr, set);
    chk("req_ready_busy", ReqReady, 1'b0);
    n = 0;
    if (lat >= 0) begin
      repeat (lat) @(negedge Clk);
      n = lat;
      MemRdVld = 1'b1; MemRdOcc = occ; MemRdLock = lock;
      @(negedge Clk);
      n++;
      MemRdVld = 1'b0; MemRdOcc = ~occ; MemRdLock = ~lock; Mod = md;
    end
    while (!RspValid && n < 40) begin
      @(negedge Clk);
      n++;
      Mod = md ^ 2'b01;
    end
    chk("latency", n, (lat >= 0) ? lat + 2 : 16);
    chk("rsp_valid", RspValid, 1'b1);
    for (int i = 0; i < hold; i++) begin
      ReqValid = 1'b1;
      @(negedge Clk);
      chk("hold_valid", RspValid, 1'b1);
      chk("hold_way", RspWay, ew);
      chk("hold_evict", RspEvict, ee);
      chk("hold_ready", ReqReady, 1'b0);
      chk("hold_rd_en", MemRdEn, 1'b0);
    end
    ReqValid = 1'b0;
    chk("rsp_way", RspWay, ew);
    chk("rsp_evict", RspEvict, ee);
    chk("rsp_fail", RspFail, ef);
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    chk("post_valid", RspValid, 1'b0);
    chk("post_ready", ReqReady, 1'b1);
    chk("evict_cnt", EvictCnt, ecnt);
  endtask
  initial begin
    repeat (3) @(negedge Clk);
    chk("rst_ready", ReqReady, 1'b1);
    chk("rst_rd_en", MemRdEn, 1'b0);
    chk("rst_valid", RspValid, 1'b0);
    chk("rst_cnt", EvictCnt, 16'd0);
    Rst = 1'b1;
    MemRdVld = 1'b1;
    @(negedge Clk);
    MemRdVld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("idle_rd_en", MemRdEn, 1'b0);
      chk("idle_valid", RspValid, 1'b0);
      chk("idle_ready", ReqReady, 1'b1);
    end
    do_req(8'h12, 1, 3'b011, 3'b000, 2'd0, 2'd2, 1'b0, 1'b0, 16'd0, 0);
    do_req(8'h21, 1, 3'b111, 3'b000, 2'd1, 2'd1, 1'b1, 1'b0, 16'd1, 0);
    do_req(8'h22, 1, 3'b111, 3'b010, 2'd1, 2'd2, 1'b1, 1'b0, 16'd2, 0);
    do_req(8'h23, 1, 3'b111, 3'b110, 2'd1, 2'd0, 1'b1, 1'b0, 16'd3, 0);
    do_req(8'h24, 1, 3'b111, 3'b000, 2'd3, 2'd0, 1'b1, 1'b0, 16'd4, 0);
    do_req(8'h30, 2, 3'b111, 3'b111, 2'd1, 2'd3, 1'b0, 1'b1, 16'd4, 0);
    do_req(8'h31, 1, 3'b110, 3'b001, 2'd0, 2'd1, 1'b1, 1'b0, 16'd5, 0);
    do_req(8'h32, 3, 3'b101, 3'b010, 2'd2, 2'd2, 1'b1, 1'b0, 16'd6, 0);
    do_req(8'h33, 1, 3'b000, 3'b001, 2'd2, 2'd1, 1'b0, 1'b0, 16'd6, 0);
    do_req(8'h40, -1, 3'b000, 3'b000, 2'd0, 2'd3, 1'b0, 1'b1, 16'd6, 0);
    do_req(8'h41, 15, 3'b111, 3'b000, 2'd2, 2'd2, 1'b1, 1'b0, 16'd7, 0);
    do_req(8'h55, 1, 3'b111, 3'b100, 2'd2, 2'd0, 1'b1, 1'b0, 16'd8, 10);
    @(negedge Clk);
    ReqValid = 1'b1; ReqSet = 8'hA5;
    @(negedge Clk);
    ReqValid = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("mid_rst_ready", ReqReady, 1'b1);
    chk("mid_rst_addr", MemRdAddr, 8'h00);
    chk("mid_rst_valid", RspValid, 1'b0);
    chk("mid_rst_way", RspWay, 2'd0);
    chk("mid_rst_cnt", EvictCnt, 16'd0);
    @(negedge Clk);
    Rst = 1'b1;
    MemRdVld = 1'b1; MemRdOcc = 3'b111;
    @(negedge Clk);
    MemRdVld = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      chk("after_rst_valid", RspValid, 1'b0);
    end
    do_req(8'h66, 1, 3'b000, 3'b000, 2'd1, 2'd0, 1'b0, 1'b0, 16'd0, 0);
    @(negedge Clk);
    force dut.EvictCnt = 16'hFFFE;
    #1;
    release dut.EvictCnt;
    do_req(8'h77, 1, 3'b111, 3'b000, 2'd0, 2'd0, 1'b1, 1'b0, 16'hFFFF, 0);
    do_req(8'h78, 1, 3'b111, 3'b000, 2'd2, 2'd2, 1'b1, 1'b0, 16'hFFFF, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
